// File: rtl/cskip_pipe_adder.sv
// Carry-skip adder pipelined one register stage per BLK-bit group, with valid/ready flow control.
// Optional signed-overflow output o_ovf is built only when CSKIP_OVF_EN is defined.
module cskip_pipe_adder #(
    parameter int WIDTH = 16,
    parameter int BLK   = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_add_term1,
    input  logic [WIDTH-1:0] i_add_term2,
    input  logic             i_cin,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_result,
    output logic             o_cout,
    output logic [15:0]      o_skip_cnt
`ifdef CSKIP_OVF_EN
    ,
    output logic             o_ovf
`endif
);

    localparam int NB = WIDTH / BLK;

    // Ripple-adds group k into the partial sum; returns {group carry-out, updated sum}.
    function automatic logic [WIDTH:0] grp_add(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b,
                                               input logic [WIDTH-1:0] s,
                                               input logic             cin,
                                               input int               k);
        logic [WIDTH-1:0] sum;
        logic             c;
        logic             p;
        sum = s;
        c   = cin;
        p   = 1'b1;
        for (int i = 0; i < BLK; i++) begin
            sum[k*BLK+i] = a[k*BLK+i] ^ b[k*BLK+i] ^ c;
            c            = (a[k*BLK+i] & b[k*BLK+i]) | (c & (a[k*BLK+i] ^ b[k*BLK+i]));
            p            = p & (a[k*BLK+i] ^ b[k*BLK+i]);
        end
        return {(p ? cin : c), sum};
    endfunction

    function automatic logic [16:0] skip_groups(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] x;
        logic [16:0]      n;
        x = a ^ b;
        n = '0;
        for (int g = 0; g < NB; g++) begin
            if (&x[g*BLK +: BLK]) n = n + 17'd1;
        end
        return n;
    endfunction

    function automatic logic [15:0] sat_add16(input logic [15:0] cnt, input logic [16:0] inc);
        logic [16:0] t;
        t = {1'b0, cnt} + inc;
        return t[16] ? 16'hFFFF : t[15:0];
    endfunction

    logic        en;
    logic [15:0] skip_cnt_d, skip_cnt_q;

    genvar k;
    for (k = 0; k < NB; k++) begin : g_stage
        logic [WIDTH-1:0] a_src, b_src, s_src;
        logic             c_src, v_src;
        logic [WIDTH:0]   grp;
        logic             v_d, v_q, c_d, c_q;
        logic [WIDTH-1:0] s_d, s_q;

        if (k == 0) begin : g_first
            assign a_src = i_add_term1;
            assign b_src = i_add_term2;
            assign s_src = '0;
            assign c_src = i_cin;
            assign v_src = i_valid;
        end else begin : g_next
            assign a_src = g_stage[k-1].g_fwd.a_q;
            assign b_src = g_stage[k-1].g_fwd.b_q;
            assign s_src = g_stage[k-1].s_q;
            assign c_src = g_stage[k-1].c_q;
            assign v_src = g_stage[k-1].v_q;
        end

        assign grp = grp_add(a_src, b_src, s_src, c_src, k);

        // Data loads only with a valid token so bubbles leave the last result visible.
        always_comb begin
            v_d = v_q;
            s_d = s_q;
            c_d = c_q;
            if (en) begin
                v_d = v_src;
                if (v_src) begin
                    s_d = grp[WIDTH-1:0];
                    c_d = grp[WIDTH];
                end
            end
        end

        always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) begin
                v_q <= 1'b0;
                s_q <= '0;
                c_q <= 1'b0;
            end else begin
                v_q <= v_d;
                s_q <= s_d;
                c_q <= c_d;
            end
        end

        if (k < NB-1) begin : g_fwd
            logic [WIDTH-1:0] a_d, a_q, b_d, b_q;

            always_comb begin
                a_d = a_q;
                b_d = b_q;
                if (en && v_src) begin
                    a_d = a_src;
                    b_d = b_src;
                end
            end

            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    a_q <= '0;
                    b_q <= '0;
                end else begin
                    a_q <= a_d;
                    b_q <= b_d;
                end
            end
        end

`ifdef CSKIP_OVF_EN
        if (k == NB-1) begin : g_ovf
            logic ovf_d, ovf_q;

            // Carry into the MSB is recovered as a ^ b ^ sum at that bit.
            always_comb begin
                ovf_d = ovf_q;
                if (en && v_src) begin
                    ovf_d = a_src[WIDTH-1] ^ b_src[WIDTH-1] ^ grp[WIDTH-1] ^ grp[WIDTH];
                end
            end

            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) ovf_q <= 1'b0;
                else       ovf_q <= ovf_d;
            end
        end
`endif
    end

    assign o_valid  = g_stage[NB-1].v_q;
    assign o_result = g_stage[NB-1].s_q;
    assign o_cout   = g_stage[NB-1].c_q;
`ifdef CSKIP_OVF_EN
    assign o_ovf    = g_stage[NB-1].g_ovf.ovf_q;
`endif

    assign en      = !o_valid || i_ready;
    assign o_ready = en;

    always_comb begin
        skip_cnt_d = skip_cnt_q;
        if (i_valid && en) begin
            skip_cnt_d = sat_add16(skip_cnt_q, skip_groups(i_add_term1, i_add_term2));
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) skip_cnt_q <= '0;
        else       skip_cnt_q <= skip_cnt_d;
    end

    assign o_skip_cnt = skip_cnt_q;

endmodule

// File: tb/tb_cskip_pipe_adder.sv
// Self-checking bench for cskip_pipe_adder: directed scenarios plus randomized traffic
// against an arithmetic reference model with an in-order expected-result queue.
module tb_cskip_pipe_adder;

    localparam int W   = 16;
    localparam int BLK = 4;
    localparam int NB  = W / BLK;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } exp_t;

    logic         clk = 1'b0;
    logic         i_rst;
    logic         i_valid;
    logic         o_ready;
    logic [W-1:0] i_add_term1;
    logic [W-1:0] i_add_term2;
    logic         i_cin;
    logic         o_valid;
    logic         i_ready;
    logic [W-1:0] o_result;
    logic         o_cout;
    logic [15:0]  o_skip_cnt;
`ifdef CSKIP_OVF_EN
    logic         o_ovf;
`endif

    int     checks = 0;
    int     errors = 0;
    exp_t   exp_q[$];
    exp_t   last_out;
    exp_t   held;
    logic   stalled;
    int     skip_exp;
    int     lat;
    int     skip_before;

    always #5 clk = ~clk;

    cskip_pipe_adder #(.WIDTH(W), .BLK(BLK)) dut (
        .i_clk       (clk),
        .i_rst       (i_rst),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .i_add_term1 (i_add_term1),
        .i_add_term2 (i_add_term2),
        .i_cin       (i_cin),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_result    (o_result),
        .o_cout      (o_cout),
        .o_skip_cnt  (o_skip_cnt)
`ifdef CSKIP_OVF_EN
        ,
        .o_ovf       (o_ovf)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
        exp_t         e;
        logic [W:0]   full;
        full   = {1'b0, a} + {1'b0, b} + (W+1)'(ci);
        e.sum  = full[W-1:0];
        e.cout = full[W];
        e.ovf  = (a[W-1] == b[W-1]) && (full[W-1] != a[W-1]);
        return e;
    endfunction

    function automatic int groups_skipped(input logic [W-1:0] a, input logic [W-1:0] b);
        int n;
        int mask;
        n    = 0;
        mask = (1 << BLK) - 1;
        for (int g = 0; g < NB; g++) begin
            if (((int'(a ^ b) >> (g * BLK)) & mask) == mask) n++;
        end
        return n;
    endfunction

    // One clock: drive, check outputs against the model, account for handshakes.
    task automatic cyc(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic ci, input logic rdy);
        exp_t e;
        @(negedge clk);
        i_valid     = v;
        i_add_term1 = a;
        i_add_term2 = b;
        i_cin       = ci;
        i_ready     = rdy;
        #1;
        chk("o_ready", 32'(o_ready), 32'(!o_valid || rdy));
        if (stalled) begin
            chk("hold_valid",  32'(o_valid),  32'd1);
            chk("hold_result", 32'(o_result), 32'(held.sum));
            chk("hold_cout",   32'(o_cout),   32'(held.cout));
`ifdef CSKIP_OVF_EN
            chk("hold_ovf",    32'(o_ovf),    32'(held.ovf));
`endif
        end
        if (o_valid && rdy) begin
            checks++;
            assert (exp_q.size() > 0) else begin
                errors++;
                $error("FAIL unexpected_token observed=valid_result expected=no_pending_token");
            end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("result", 32'(o_result), 32'(e.sum));
                chk("cout",   32'(o_cout),   32'(e.cout));
`ifdef CSKIP_OVF_EN
                chk("ovf",    32'(o_ovf),    32'(e.ovf));
`endif
                last_out = e;
            end
        end else if (!o_valid) begin
            chk("idle_result", 32'(o_result), 32'(last_out.sum));
            chk("idle_cout",   32'(o_cout),   32'(last_out.cout));
        end
        stalled = o_valid && !rdy && (exp_q.size() > 0);
        if (stalled) held = exp_q[0];
        if (v && o_ready) begin
            exp_q.push_back(model(a, b, ci));
            skip_exp = skip_exp + groups_skipped(a, b);
            if (skip_exp > 16'hFFFF) skip_exp = 16'hFFFF;
        end
        @(posedge clk);
        #1;
        chk("skip_cnt", 32'(o_skip_cnt), 32'(skip_exp));
    endtask

    task automatic measure_latency(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
        cyc(1'b1, a, b, ci, 1'b1);
        lat = 1;
        while (!o_valid && lat < 20) begin
            cyc(1'b0, '0, '0, 1'b0, 1'b1);
            lat++;
        end
        chk("latency", 32'(lat), 32'(NB));
    endtask

    task automatic reset_checks();
        chk("rst_valid",  32'(o_valid),    32'd0);
        chk("rst_result", 32'(o_result),   32'd0);
        chk("rst_cout",   32'(o_cout),     32'd0);
        chk("rst_skip",   32'(o_skip_cnt), 32'd0);
        chk("rst_ready",  32'(o_ready),    32'd1);
`ifdef CSKIP_OVF_EN
        chk("rst_ovf",    32'(o_ovf),      32'd0);
`endif
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        i_rst       = 1'b1;
        i_valid     = 1'b0;
        i_add_term1 = '0;
        i_add_term2 = '0;
        i_cin       = 1'b0;
        i_ready     = 1'b1;
        exp_q.delete();
        last_out    = '0;
        held        = '0;
        stalled     = 1'b0;
        skip_exp    = 0;
        #2;
        reset_checks();
        repeat (2) @(posedge clk);
        @(negedge clk);
        i_rst = 1'b0;

        // Basic sum and latency
        measure_latency(16'h00FF, 16'h0001, 1'b0);
        chk("sum_00ff_0001", 32'(o_result), 32'h0100);
        chk("cout_00ff_0001", 32'(o_cout), 32'd0);
        cyc(1'b0, '0, '0, 1'b0, 1'b1);

        // All groups propagate: full carry-skip chain
        skip_before = skip_exp;
        cyc(1'b1, 16'hFFFF, 16'h0000, 1'b1, 1'b1);
        chk("skip_plus4", 32'(o_skip_cnt), 32'(skip_before + 4));
        repeat (NB) cyc(1'b0, '0, '0, 1'b0, 1'b1);
        chk("wrap_result", 32'(o_result), 32'h0000);
        chk("wrap_cout", 32'(o_cout), 32'd1);

        // Signed overflow corners
        cyc(1'b1, 16'h7FFF, 16'h0001, 1'b0, 1'b1);
        cyc(1'b1, 16'h8000, 16'h8000, 1'b0, 1'b1);
        repeat (NB + 1) cyc(1'b0, '0, '0, 1'b0, 1'b1);

        // Back-to-back tokens with a two-cycle downstream stall
        cyc(1'b1, 16'h1234, 16'h4321, 1'b0, 1'b1);
        cyc(1'b1, 16'hAAAA, 16'h5555, 1'b1, 1'b1);
        cyc(1'b1, 16'hF0F0, 16'h0F0F, 1'b0, 1'b1);
        lat = 0;
        while (!o_valid && lat < 20) begin
            cyc(1'b0, '0, '0, 1'b0, 1'b1);
            lat++;
        end
        cyc(1'b0, '0, '0, 1'b0, 1'b0);
        chk("stall_ready0", 32'(o_ready), 32'd0);
        cyc(1'b1, 16'h0001, 16'h0001, 1'b0, 1'b0);
        chk("stall_ready1", 32'(o_ready), 32'd0);
        repeat (NB + 3) cyc(1'b0, '0, '0, 1'b0, 1'b1);
        chk("stall_drained", 32'(exp_q.size()), 32'd0);

        // Reset with three tokens in flight
        cyc(1'b1, 16'h1111, 16'h2222, 1'b0, 1'b1);
        cyc(1'b1, 16'h3333, 16'h4444, 1'b1, 1'b1);
        cyc(1'b1, 16'h5555, 16'hAAAA, 1'b0, 1'b1);
        @(negedge clk);
        i_valid = 1'b0;
        i_rst   = 1'b1;
        #1;
        reset_checks();
        exp_q.delete();
        skip_exp = 0;
        last_out = '0;
        stalled  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        i_rst = 1'b0;
        repeat (NB + 3) cyc(1'b0, '0, '0, 1'b0, 1'b1);
        measure_latency(16'h0F0F, 16'h00F1, 1'b1);
        cyc(1'b0, '0, '0, 1'b0, 1'b1);

        // Randomized traffic with random backpressure
        for (int n = 0; n < 400; n++) begin
            ra = W'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? ~ra : W'($urandom);
            cyc(($urandom_range(0, 3) != 0), ra, rb, 1'($urandom_range(0, 1)),
                ($urandom_range(0, 3) != 0));
        end
        repeat (NB + 3) cyc(1'b0, '0, '0, 1'b0, 1'b1);
        chk("random_drained", 32'(exp_q.size()), 32'd0);

        // Drive the skip counter into saturation
        for (int n = 0; n < 16390; n++) begin
            cyc(1'b1, 16'hFFFF, 16'h0000, 1'b0, 1'b1);
        end
        chk("skip_saturated", 32'(o_skip_cnt), 32'h0000FFFF);
        cyc(1'b1, 16'hFFFF, 16'h0000, 1'b1, 1'b1);
        chk("skip_sat_hold", 32'(o_skip_cnt), 32'h0000FFFF);
        repeat (NB + 2) cyc(1'b0, '0, '0, 1'b0, 1'b1);
        chk("final_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
